// File: rtl/neural_engine_pkg.sv
// Shared types and default widths for the neural engine compute and control blocks.
package neural_engine_pkg;

  localparam int NE_DATA_W = 16;
  localparam int NE_ACC_W  = 40;
  localparam int NE_ADDR_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } dpe_state_t;

endpackage

// File: rtl/dot_product_engine_mac_unit.sv
// Signed multiply-accumulate; the full-width product is sign-extended and summed modulo 2^ACC_W.
module mac_unit
  import neural_engine_pkg::*;
#(
  parameter int DATA_W = NE_DATA_W,
  parameter int ACC_W  = NE_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod_s;

  assign prod_s = (2*DATA_W)'(a) * (2*DATA_W)'(b);

  // Accumulator register: clear wins over accumulate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod_s);
    end else begin
      acc <= acc;
    end
  end

endmodule

// File: rtl/dot_product_engine.sv
// Run-phase dot product: streams activations, fetches matching weights, accumulates, hands off the sum.
module dot_product_engine
  import neural_engine_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = NE_ADDR_W,
  parameter int DATA_W = NE_DATA_W,
  parameter int ACC_W  = NE_ACC_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_run,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic [DATA_W-1:0] act_data,
  input  logic              act_valid,
  output logic              act_ready,
  output logic [ACC_W-1:0]  result_data,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  dpe_state_t               state_r;
  dpe_state_t               next_state_s;
  logic [ADDR_W-1:0]        idx_r;
  logic signed [DATA_W-1:0] act_q_r;
  logic                     acc_en_r;
  logic                     act_ready_r;
  logic                     result_valid_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     accept_s;
  logic                     clr_s;
  logic                     act_ready_nx_s;
  logic                     result_valid_nx_s;
  logic                     busy_nx_s;
  logic                     done_nx_s;
  logic signed [ACC_W-1:0]  acc_s;

  // act_ready_r is only ever high in FETCH, so an accept implies FETCH
  assign accept_s    = act_valid & act_ready_r;
  assign clr_s       = (state_r == ST_IDLE) & start_run;
  assign mem_rd_en   = accept_s;
  assign mem_rd_addr = accept_s ? idx_r : '0;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:   next_state_s = start_run ? ST_FETCH : ST_IDLE;
      ST_FETCH:  next_state_s = (accept_s && (idx_r == LAST_IDX)) ? ST_DRAIN : ST_FETCH;
      ST_DRAIN:  next_state_s = ST_OUTPUT;
      ST_OUTPUT: next_state_s = result_ready ? ST_IDLE : ST_OUTPUT;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every handshake output is a flop
  always_comb begin
    act_ready_nx_s    = 1'b0;
    result_valid_nx_s = 1'b0;
    busy_nx_s         = 1'b0;
    done_nx_s         = 1'b0;
    case (next_state_s)
      ST_IDLE: begin
        busy_nx_s = 1'b0;
        done_nx_s = (state_r == ST_OUTPUT);
      end
      ST_FETCH: begin
        act_ready_nx_s = 1'b1;
        busy_nx_s      = 1'b1;
      end
      ST_DRAIN: busy_nx_s = 1'b1;
      ST_OUTPUT: begin
        result_valid_nx_s = 1'b1;
        busy_nx_s         = 1'b1;
      end
      default: busy_nx_s = 1'b0;
    endcase
  end

  // Registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_ready_r    <= 1'b0;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      act_ready_r    <= act_ready_nx_s;
      result_valid_r <= result_valid_nx_s;
      busy_r         <= busy_nx_s;
      done_r         <= done_nx_s;
    end
  end

  // Index counter, activation capture and accumulate-enable pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_r    <= '0;
      act_q_r  <= '0;
      acc_en_r <= 1'b0;
    end else begin
      acc_en_r <= accept_s;
      if (clr_s) begin
        idx_r <= '0;
      end else if (accept_s) begin
        idx_r <= idx_r + ADDR_W'(1);
      end else begin
        idx_r <= idx_r;
      end
      if (accept_s) begin
        act_q_r <= act_data;
      end else begin
        act_q_r <= act_q_r;
      end
    end
  end

  // Weight arrives one cycle after the read, lined up with act_q_r and acc_en_r
  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_s),
    .en      (acc_en_r),
    .a       (act_q_r),
    .b       (mem_rd_data),
    .acc     (acc_s)
  );

  assign act_ready    = act_ready_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign result_data  = acc_s;

endmodule
